// File: rtl/softmax_max_sub.sv
// softmax_max_sub: buffers one row of signed scores, tracks the row maximum,
// then hands x_i - max (clamped to X_MIN) to the exp unit one element at a time
// over the start_exp / exp_done handshake.
//
// state | meaning
// IDLE  | waiting for the first score of a row
// LOAD  | accepting the remaining scores, updating row_max
// ISSUE | x_out/out_idx freshly loaded, start_exp pulsed
// WAIT  | holding x_out until the exp unit reports exp_done
// DONE  | one-cycle row_done pulse
module softmax_max_sub #(
  parameter int ROW_LEN    = 4,
  parameter int DATA_WIDTH = 33,
  parameter int FRAC_BITS  = 16,
  parameter int X_MIN      = -(8 * (2 ** FRAC_BITS))
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         in_ready,
  output logic                         start_exp,
  output logic [DATA_WIDTH-1:0]        x_out,
  input  logic                         exp_done,
  output logic [$clog2(ROW_LEN):0]     out_idx,
  output logic [DATA_WIDTH-1:0]        row_max,
  output logic                         busy,
  output logic                         row_done
);

  localparam int IW = $clog2(ROW_LEN) + 1;
  localparam int AW = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam logic [IW-1:0] LAST = IW'(ROW_LEN - 1);
  localparam logic signed [DATA_WIDTH:0] X_MIN_EXT = (DATA_WIDTH + 1)'(X_MIN);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0] row_buf [ROW_LEN];
  logic [IW-1:0]         cnt;

  logic                  accept;
  logic                  last_accept;
  logic                  advance;
  logic [AW-1:0]         wr_addr;
  logic [DATA_WIDTH-1:0] max_next;
  logic [IW-1:0]         issue_idx;
  logic [DATA_WIDTH-1:0] issue_elem;
  logic [DATA_WIDTH-1:0] issue_max;
  logic signed [DATA_WIDTH:0] diff;
  logic [DATA_WIDTH-1:0] x_next;

  // Ready is forced low while reset is held, even though state is already IDLE.
  assign in_ready  = !rst && ((state == ST_IDLE) || (state == ST_LOAD));
  assign start_exp = (state == ST_ISSUE);
  assign busy      = (state == ST_ISSUE) || (state == ST_WAIT) || (state == ST_DONE);
  assign row_done  = (state == ST_DONE);

  // Accept/issue decode and the subtract-and-clamp for the element about to be issued.
  always_comb begin
    accept      = in_ready && in_valid;
    wr_addr     = (state == ST_IDLE) ? '0 : cnt[AW-1:0];

    if (state == ST_IDLE)
      max_next = in_data;
    else if ($signed(in_data) > $signed(row_max))
      max_next = in_data;
    else
      max_next = row_max;

    last_accept = accept && (((state == ST_IDLE) && (ROW_LEN == 1)) ||
                             ((state == ST_LOAD) && (cnt == LAST)));
    advance     = (state == ST_WAIT) && exp_done && (out_idx != LAST);

    // First issue of a row uses the max that already includes the element
    // being accepted on this same edge.
    issue_idx  = '0;
    issue_elem = (ROW_LEN == 1) ? in_data : row_buf[0];
    issue_max  = max_next;
    if (advance) begin
      issue_idx  = out_idx + 1'b1;
      issue_elem = row_buf[issue_idx[AW-1:0]];
      issue_max  = row_max;
    end

    // One extra bit so the difference of two extreme scores cannot wrap.
    diff   = {issue_elem[DATA_WIDTH-1], issue_elem} - {issue_max[DATA_WIDTH-1], issue_max};
    x_next = (diff < X_MIN_EXT) ? X_MIN_EXT[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept) state_next = last_accept ? ST_ISSUE : ST_LOAD;
      ST_LOAD:  if (last_accept) state_next = ST_ISSUE;
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT:  if (exp_done) state_next = (out_idx == LAST) ? ST_DONE : ST_ISSUE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Row buffer write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (accept) row_buf[wr_addr] <= in_data;
  end

  // Element counter, running maximum and the registered exp-unit operand.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      row_max <= '0;
      x_out   <= '0;
      out_idx <= '0;
    end else begin
      if (accept) begin
        row_max <= max_next;
        cnt     <= (state == ST_IDLE) ? IW'(1) : cnt + 1'b1;
      end
      if (last_accept || advance) begin
        x_out   <= x_next;
        out_idx <= issue_idx;
      end
    end
  end

endmodule

// File: tb/tb_softmax_max_sub.sv
// Directed bench for softmax_max_sub (ROW_LEN=4, Q16): row table plus reset-in-WAIT sequence.
module tb_softmax_max_sub;
  localparam int DW = 33;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          exp_done = 1'b0;
  logic          in_ready;
  logic          start_exp;
  logic [DW-1:0] x_out;
  logic [2:0]    out_idx;
  logic [DW-1:0] row_max;
  logic          busy;
  logic          row_done;

  softmax_max_sub #(
    .ROW_LEN(4), .DATA_WIDTH(DW), .FRAC_BITS(16), .X_MIN(-524288)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .start_exp(start_exp), .x_out(x_out), .exp_done(exp_done), .out_idx(out_idx),
    .row_max(row_max), .busy(busy), .row_done(row_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d [4];
    logic [DW-1:0] mx;
    logic [DW-1:0] x [4];
    int            dly;
    bit            hold;
  } row_t;

  row_t rows [5];

  int n_pass = 0;
  int n_total = 0;
  int n_start = 0;
  int n_rowdone = 0;

  always @(negedge clk) begin
    if (start_exp) n_start++;
    if (row_done) n_rowdone++;
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic feed(input int r);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("in_ready_load", in_ready, 1);
      in_valid = 1'b1;
      in_data  = rows[r].d[k];
      exp_done = (rows[r].hold && k == 2);
    end
    @(negedge clk);
    exp_done = 1'b0;
    if (rows[r].hold) in_data = 33'h0FFFFFFFF;
    else in_valid = 1'b0;
  endtask

  task automatic drain(input int r, input int s0, input int d0);
    int waited;
    for (int e = 0; e < 4; e++) begin
      waited = 0;
      while (!start_exp && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      if (!start_exp) begin
        check("start_timeout", 0, 1);
        return;
      end
      check("start_latency", waited, 0);
      check("x_out", x_out, rows[r].x[e]);
      check("out_idx", out_idx, e);
      check("in_ready_issue", in_ready, 0);
      check("busy_issue", busy, 1);
      @(negedge clk);
      check("start_width", start_exp, 0);
      for (int i = 0; i < rows[r].dly; i++) begin
        check("x_out_stable", x_out, rows[r].x[e]);
        check("in_ready_wait", in_ready, 0);
        @(negedge clk);
      end
      exp_done = 1'b1;
      @(negedge clk);
      exp_done = 1'b0;
    end
    check("row_done_pulse", row_done, 1);
    check("busy_done", busy, 1);
    check("in_ready_done", in_ready, 0);
    in_valid = 1'b0;
    @(negedge clk);
    check("row_done_low", row_done, 0);
    check("busy_idle", busy, 0);
    check("in_ready_idle", in_ready, 1);
    check("row_max", row_max, rows[r].mx);
    check("start_count", n_start - s0, 4);
    check("row_done_count", n_rowdone - d0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int s0, d0;

    rows[0].d = '{33'd0, -33'sd32768, -33'sd65536, -33'sd131072};
    rows[0].mx = 33'd0;
    rows[0].x = '{33'd0, -33'sd32768, -33'sd65536, -33'sd131072};
    rows[0].dly = 0; rows[0].hold = 0;

    rows[1].d = '{33'd65536, 33'd196608, 33'd131072, 33'd196608};
    rows[1].mx = 33'd196608;
    rows[1].x = '{-33'sd131072, 33'd0, -33'sd65536, 33'd0};
    rows[1].dly = 1; rows[1].hold = 0;

    rows[2].d = '{33'd655360, -33'sd655360, 33'd0, 33'd655360};
    rows[2].mx = 33'd655360;
    rows[2].x = '{33'd0, -33'sd524288, -33'sd524288, 33'd0};
    rows[2].dly = 2; rows[2].hold = 0;

    rows[3] = rows[2];
    rows[3].dly = 5; rows[3].hold = 1;

    rows[4].d = '{33'h0FFFFFFFF, 33'h100000000, 33'd0, 33'd0};
    rows[4].mx = 33'h0FFFFFFFF;
    rows[4].x = '{33'd0, -33'sd524288, -33'sd524288, -33'sd524288};
    rows[4].dly = 0; rows[4].hold = 0;

    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_start", start_exp, 0);
    check("rst_x_out", x_out, 0);
    check("rst_row_max", row_max, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int r = 0; r < 5; r++) begin
      s0 = n_start;
      d0 = n_rowdone;
      feed(r);
      drain(r, s0, d0);
    end

    // Reset while waiting on the second element.
    feed(0);
    check("pre_rst_start", start_exp, 1);
    @(negedge clk);
    exp_done = 1'b1;
    @(negedge clk);
    exp_done = 1'b0;
    check("pre_rst_x_out", x_out, rows[0].x[1]);
    @(negedge clk);
    check("pre_rst_wait", busy, 1);
    s0 = n_start;
    d0 = n_rowdone;
    #1 rst = 1'b1;
    #1;
    check("async_rst_x_out", x_out, 0);
    check("async_rst_out_idx", out_idx, 0);
    check("async_rst_row_max", row_max, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_in_ready", in_ready, 0);
    exp_done = 1'b1;
    repeat (3) @(negedge clk);
    exp_done = 1'b0;
    check("rst_no_start", n_start - s0, 0);
    check("rst_no_row_done", n_rowdone - d0, 0);
    rst = 1'b0;
    s0 = n_start;
    d0 = n_rowdone;
    feed(0);
    drain(0, s0, d0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
